rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (we3/wa3/wd3) between NREQ writeback requesters, e.g. ALU result, load data and multiply/divide result.
- Per-requester valid/ready handshake with round-robin arbitration.
- Registers the winning write for one cycle, then drives the register-file write port.
- Drops writes to register 0, supports stall and flush from the pipeline controller, and keeps a committed-write counter.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  requester i has a write pending
- req_addr  in  NREQ*AW  requester i destination register, packed; slot i at [i*AW +: AW]
- req_data  in  NREQ*DW  requester i write data, packed; slot i at [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- stall  in  1  pipeline hold; no grants this cycle
- flush  in  1  kill; no grants this cycle
- rf_we  out  1  to regfile we3
- rf_wa  out  AW  to regfile wa3
- rf_wd  out  DW  to regfile wd3
- wr_count  out  16  number of committed writes, saturating

Behaviour:
- Reset (async, active-high):
  - rf_we=0, rf_wa=0, rf_wd=0, wr_count=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 while reset is asserted.
- Arbitration (combinational, same cycle):
  - If stall=0 and flush=0, search req_valid in order rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ..., rr_ptr-1.
  - The first set bit i wins, and req_ready is one-hot at bit i.
  - If no requester is valid, req_ready=0.
  - req_ready may depend on req_valid.
  - Requesters must hold valid/addr/data stable until accepted; they must not depend on ready to raise valid.
- Pointer update:
  - On a transfer by requester i, rr_ptr <= (i+1) mod NREQ.
  - With no transfer, rr_ptr holds.
  - Wrap: a grant to NREQ-1 sets rr_ptr=0.
- Output stage (one cycle latency):
  - A transfer in cycle t gives, in cycle t+1: rf_wa=req_addr[i], rf_wd=req_data[i], rf_we=(req_addr[i]!=0).
  - With no transfer in cycle t: rf_we=0 in cycle t+1, and rf_wa/rf_wd hold their previous values.
- Register 0:
  - A transfer with addr 0 completes the handshake normally.
  - It produces rf_we=0 and does not increment wr_count.
- stall=1: req_ready=0 and rf_we <= 0 next cycle. rr_ptr holds.
- flush=1:
  - Same as stall; flush and stall together behave identically.
  - A write already registered in the output stage in the flush cycle still commits, because flush only blocks new grants.
- wr_count:
  - Increments on every cycle with rf_we=1, i.e. registered at the edge after the write is issued.
  - Saturates at 16'hFFFF; no wrap.
- Back-to-back transfers: one transfer per cycle maximum, so there is full throughput with continuous requests.
- Reset mid-operation: any registered write is discarded (rf_we=0 immediately) and pending requests are re-arbitrated from rr_ptr=0.

Optional Feature:
- Macro: RF_WB_FWD_EN.
- When defined, add ports:
  - ra1, ra2  in  AW
  - rf_rd1, rf_rd2  in  DW (regfile read data)
  - fwd_rd1, fwd_rd2  out  DW
- Forwarding rule: fwd_rdN = rf_wd when rf_we=1 and raN==rf_wa and raN!=0; otherwise fwd_rdN = rf_rdN. This logic is combinational.
- When undefined, these ports and the logic are absent, and the block behaves identically otherwise.

Test Plan:
- Reset mid-write: assert reset while rf_we=1 -> rf_we, rf_wa, rf_wd and wr_count read 0 immediately; after release, the first grant goes to requester 0.
- Single request: valid[1]=1, addr=5, data=32'hDEADBEEF -> ready=3'b010 the same cycle; next cycle rf_we=1, rf_wa=5, rf_wd=DEADBEEF; wr_count=1 after that edge.
- All three valid continuously from reset -> grants in order 0, 1, 2, 0, 1, one per cycle; rf_we=1 every cycle from the second cycle on.
- Register 0: requester 2 writes addr 0, data 32'h1234 -> ready[2]=1; next cycle rf_we=0 and wr_count unchanged.
- Stall/flush: stall=1 for 3 cycles with valid[0]=1 -> ready=0 and rf_we=0 throughout; the grant occurs on the first cycle with stall=0. A flush in the cycle after a transfer still commits that write.
- Saturation: preload wr_count to 16'hFFFE through 2 writes near the limit (or by force) -> reads FFFF and stays at FFFF.
- Forwarding (with RF_WB_FWD_EN defined): rf_we=1, rf_wa=7, ra1=7 -> fwd_rd1=rf_wd; with ra1=0 -> fwd_rd1=rf_rd1.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port (we3/wa3/wd3) between
// NREQ writeback requesters. It uses round-robin valid/ready arbitration and
// a one-cycle registered output stage. Writes to register 0 complete the
// handshake but are never issued. The block also keeps a saturating count of
// committed writes.
//
// Optional feature: define RF_WB_FWD_EN to add the read-port forwarding
// outputs fwd_rd1/fwd_rd2. These bypass the write in the output stage.
module rf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               reset,
`ifdef RF_WB_FWD_EN
    input  logic [AW-1:0]      ra1,
    input  logic [AW-1:0]      ra2,
    input  logic [DW-1:0]      rf_rd1,
    input  logic [DW-1:0]      rf_rd2,
    output logic [DW-1:0]      fwd_rd1,
    output logic [DW-1:0]      fwd_rd2,
`endif
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               stall,
    input  logic               flush,
    output logic               rf_we,
    output logic [AW-1:0]      rf_wa,
    output logic [DW-1:0]      rf_wd,
    output logic [15:0]        wr_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   grant_idx;
    logic [NREQ-1:0] grant;
    logic            xfer;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;

    // (base + off) mod NREQ, for off in 0..NREQ.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) sum = sum - NREQ;
        return PW'(sum);
    endfunction

    // Round-robin search starting at rr_ptr. Stall, flush or reset block every grant.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        grant     = '0;
        grant_idx = '0;
        xfer      = 1'b0;
        if (!reset && !stall && !flush) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!xfer && req_valid[wrap_idx(rr_ptr, k)]) begin
                    grant_idx        = wrap_idx(rr_ptr, k);
                    grant[grant_idx] = 1'b1;
                    xfer             = 1'b1;
                end
            end
        end
    end

    assign req_ready = grant;
    assign win_addr  = req_addr[grant_idx*AW +: AW];
    assign win_data  = req_data[grant_idx*DW +: DW];

    // Pointer moves to one past the winner. It holds when nothing transfers.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= wrap_idx(grant_idx, 1);
        end
    end

    // Output stage: register the winning write. An address of 0 never asserts we.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= xfer && (win_addr != '0);
            if (xfer) begin
                rf_wa <= win_addr;
                rf_wd <= win_data;
            end
        end
    end

    // Count each cycle a write is issued. The count saturates instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_count <= '0;
        end else if (rf_we && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
        end
    end

`ifdef RF_WB_FWD_EN
    // Bypass the write in the output stage to the read ports. Register 0 is never forwarded.
    always_comb begin
        fwd_rd1 = (rf_we && (ra1 == rf_wa) && (ra1 != '0)) ? rf_wd : rf_rd1;
        fwd_rd2 = (rf_we && (ra2 == rf_wa) && (ra2 != '0)) ? rf_wd : rf_rd2;
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed-vector bench for rf_wb_arbiter with a scoreboard. The stimulus
// pushes each expected register-file write. A monitor pops and compares the
// expected write whenever the DUT asserts rf_we.
module tb_rf_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               stall, flush;
    logic               rf_we;
    logic [AW-1:0]      rf_wa;
    logic [DW-1:0]      rf_wd;
    logic [15:0]        wr_count;
`ifdef RF_WB_FWD_EN
    logic [AW-1:0]      ra1, ra2;
    logic [DW-1:0]      rf_rd1, rf_rd2, fwd_rd1, fwd_rd2;
`endif

    wr_t sb[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    logic [AW-1:0] tbl_addr [NREQ] = '{5'd1, 5'd2, 5'd3};
    logic [DW-1:0] tbl_data [NREQ] = '{32'hA000_0000, 32'hA111_1111, 32'hA222_2222};

    rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef RF_WB_FWD_EN
        .ra1       (ra1),
        .ra2       (ra2),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2),
        .fwd_rd1   (fwd_rd1),
        .fwd_rd2   (fwd_rd2),
`endif
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .stall     (stall),
        .flush     (flush),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Monitor: each issued write must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && rf_we) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got wa=%0h wd=%0h, expected no write (t=%0t)", rf_wa, rf_wd, $time);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 64'(rf_wa), 64'(e.addr));
                check("wr_data", 64'(rf_wd), 64'(e.data));
            end
        end
    end

    // Watchdog: the run must end by itself.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NREQ-1:0] exp_rr [5];
        exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0;
`ifdef RF_WB_FWD_EN
        ra1 = '0; ra2 = '0; rf_rd1 = '0; rf_rd2 = '0;
`endif
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, tbl_addr[i], tbl_data[i]);

        // Reset state, with all requesters already valid.
        @(negedge clk); #1;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_we", 64'(rf_we), 64'd0);
        check("rst_wa", 64'(rf_wa), 64'd0);
        check("rst_wd", 64'(rf_wd), 64'd0);
        check("rst_count", 64'(wr_count), 64'd0);

        // All three requesters valid continuously: grants 0,1,2,0,1.
        @(negedge clk); reset = 1'b0; #1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(negedge clk); #1;
                check("b2b_we", 64'(rf_we), 64'd1);
            end
            check("rr_grant", 64'(req_ready), 64'(exp_rr[k]));
            for (int i = 0; i < NREQ; i++)
                if (exp_rr[k][i]) expect_wr(tbl_addr[i], tbl_data[i]);
        end
        @(negedge clk); req_valid = '0; #1;
        check("idle_ready", 64'(req_ready), 64'd0);
        check("b2b_count", 64'(wr_count), 64'd4);

        // Single request from requester 1 (rr_ptr=2 now).
        @(negedge clk); set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF); #1;
        check("single_ready", 64'(req_ready), 64'b010);
        check("single_count0", 64'(wr_count), 64'd5);
        expect_wr(5'd5, 32'hDEAD_BEEF);
        @(negedge clk); req_valid = '0; #1;
        check("single_count1", 64'(wr_count), 64'd5);

        // Register 0 write from requester 2.
        @(negedge clk); set_req(2, 1'b1, 5'd0, 32'h0000_1234); #1;
        check("single_count2", 64'(wr_count), 64'd6);
        check("r0_ready", 64'(req_ready), 64'b100);
        @(negedge clk); req_valid = '0; #1;
        check("r0_we", 64'(rf_we), 64'd0);
        check("r0_wa", 64'(rf_wa), 64'd0);
        check("r0_wd", 64'(rf_wd), 64'h1234);
        @(negedge clk); #1;
        check("r0_count", 64'(wr_count), 64'd6);

        // Stall for 3 cycles with requester 0 valid.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                set_req(0, 1'b1, 5'd9, 32'h5555_0000);
                stall = 1'b1;
            end
            #1;
            check("stall_ready", 64'(req_ready), 64'd0);
            check("stall_we", 64'(rf_we), 64'd0);
        end
        @(negedge clk); stall = 1'b0; #1;
        check("unstall_ready", 64'(req_ready), 64'b001);
        expect_wr(5'd9, 32'h5555_0000);

        // Flush after the transfer: the registered write still commits.
        @(negedge clk); req_valid[0] = 1'b0; set_req(1, 1'b1, 5'd10, 32'h0000_0777); flush = 1'b1; #1;
        check("flush_ready", 64'(req_ready), 64'd0);
        check("flush_we", 64'(rf_we), 64'd1);
        @(negedge clk); stall = 1'b1; #1;
        check("stflush_ready", 64'(req_ready), 64'd0);
        check("stflush_we", 64'(rf_we), 64'd0);
        check("flush_count", 64'(wr_count), 64'd7);
        @(negedge clk); stall = 1'b0; flush = 1'b0; #1;
        check("postflush_ready", 64'(req_ready), 64'b010);
        expect_wr(5'd10, 32'h0000_0777);

        // Reset while a write sits in the output stage (rr_ptr=2 before reset).
        @(negedge clk); req_valid = '0; #1;
        check("prerst_we", 64'(rf_we), 64'd1);
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, tbl_addr[i], tbl_data[i]);
        #1;
        check("midrst_we", 64'(rf_we), 64'd0);
        check("midrst_wa", 64'(rf_wa), 64'd0);
        check("midrst_wd", 64'(rf_wd), 64'd0);
        check("midrst_count", 64'(wr_count), 64'd0);
        check("midrst_ready", 64'(req_ready), 64'd0);
        @(negedge clk); reset = 1'b0; #1;
        check("postrst_ready", 64'(req_ready), 64'b001);
        expect_wr(tbl_addr[0], tbl_data[0]);
        @(negedge clk); req_valid = '0; #1;
        @(negedge clk); #1;
        check("postrst_count", 64'(wr_count), 64'd1);

        // Saturation: preload the counter near the limit, then issue two writes (rr_ptr=1).
        force dut.wr_count = 16'hFFFE;
        #1;
        release dut.wr_count;
        set_req(1, 1'b1, 5'd6, 32'hC0DE_0001);
        set_req(2, 1'b1, 5'd7, 32'hC0DE_0002);
        #1;
        check("sat_ready1", 64'(req_ready), 64'b010);
        expect_wr(5'd6, 32'hC0DE_0001);
        @(negedge clk); req_valid[1] = 1'b0; #1;
        check("sat_ready2", 64'(req_ready), 64'b100);
        expect_wr(5'd7, 32'hC0DE_0002);
        @(negedge clk); req_valid = '0; #1;
        check("sat_reach", 64'(wr_count), 64'hFFFF);
`ifdef RF_WB_FWD_EN
        // rf_we=1, rf_wa=7, rf_wd=C0DE0002 in this cycle.
        ra1 = 5'd7; ra2 = 5'd0; rf_rd1 = 32'h1111_1111; rf_rd2 = 32'h2222_2222; #1;
        check("fwd_hit", 64'(fwd_rd1), 64'hC0DE_0002);
        check("fwd_r0", 64'(fwd_rd2), 64'h2222_2222);
        ra1 = 5'd0; #1;
        check("fwd_miss", 64'(fwd_rd1), 64'h1111_1111);
`endif
        @(negedge clk); #1;
        check("sat_hold", 64'(wr_count), 64'hFFFF);
        @(negedge clk); #1;
        check("sat_idle", 64'(wr_count), 64'hFFFF);

        // Every expected write must have been observed.
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
